// File: rtl/dac_spi_driver.sv
// -----------------------------------------------------------------------------
// dac_spi_driver
//
// Serialises one 8-bit waveform sample into a 16-bit DAC frame
// {CTRL_BITS, data_in, 4'b0000}, sent MSB first over an SPI-style link.
// The DAC samples dac_din on the rising edge of dac_sclk. dac_din moves on
// falling edges, so each bit is stable across its rising edge.
//
// Parameters
//   SCLK_DIV   dac_sclk half-period in clk cycles (1..255)
//   CTRL_BITS  4-bit DAC control field placed at the top of every frame
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   data_in   in   8-bit sample, captured when start is accepted
//   start     in   transmit request, honoured only when idle
//   busy      out  high while a frame (including the CS-high hold) is running
//   done      out  one-cycle pulse when the frame and its hold time finish
//   dac_cs_n  out  DAC chip select, active low
//   dac_sclk  out  DAC serial clock, idles low
//   dac_din   out  DAC serial data
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module dac_spi_driver #(
  parameter int unsigned SCLK_DIV  = 4,
  parameter logic [3:0]  CTRL_BITS = 4'b0111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_din
);

  // The divider needs at least one bit, even when SCLK_DIV is 1.
  localparam int unsigned    DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg,   div_next;
  logic [4:0]       edge_reg,  edge_next;   // dac_sclk toggles seen, 0..31
  logic [14:0]      bits_reg,  bits_next;   // frame bits still to be sent
  logic             cs_n_reg,  cs_n_next;
  logic             sclk_reg,  sclk_next;
  logic             din_reg,   din_next;
  logic             busy_reg,  busy_next;
  logic             done_reg,  done_next;

  logic [15:0]      frame;

  assign frame = {CTRL_BITS, data_in, 4'b0000};

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      edge_reg  <= '0;
      bits_reg  <= '0;
      cs_n_reg  <= 1'b1;
      sclk_reg  <= 1'b0;
      din_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      edge_reg  <= edge_next;
      bits_reg  <= bits_next;
      cs_n_reg  <= cs_n_next;
      sclk_reg  <= sclk_next;
      din_reg   <= din_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    edge_next  = edge_reg;
    bits_next  = bits_reg;
    cs_n_next  = cs_n_reg;
    sclk_next  = sclk_reg;
    din_next   = din_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          // Capture the whole frame now so later data_in changes cannot
          // leak into it. The MSB goes straight onto dac_din.
          state_next = SHIFT;
          div_next   = '0;
          edge_next  = '0;
          bits_next  = frame[14:0];
          cs_n_next  = 1'b0;
          sclk_next  = 1'b0;
          din_next   = frame[15];
          busy_next  = 1'b1;
        end
      end

      SHIFT: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (edge_reg == 5'd31) begin
            // 32nd toggle is the 16th falling edge: end the frame here
            // instead of moving on to a 17th bit.
            state_next = HOLD;
            edge_next  = '0;
            bits_next  = '0;
            cs_n_next  = 1'b1;
            sclk_next  = 1'b0;
            din_next   = 1'b0;
          end else begin
            edge_next = edge_reg + 5'd1;
            sclk_next = ~sclk_reg;
            if (sclk_reg) begin
              // Falling edge: present the next bit.
              din_next  = bits_reg[14];
              bits_next = {bits_reg[13:0], 1'b0};
            end
          end
        end else begin
          div_next = div_reg + DIV_ONE;
        end
      end

      HOLD: begin
        // Keep CS high for SCLK_DIV cycles before the next frame may start.
        if (div_reg == DIV_LAST) begin
          state_next = IDLE;
          div_next   = '0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          div_next = div_reg + DIV_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        cs_n_next  = 1'b1;
        sclk_next  = 1'b0;
        din_next   = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign dac_cs_n = cs_n_reg;
  assign dac_sclk = sclk_reg;
  assign dac_din  = din_reg;

endmodule

// File: tb/tb_dac_spi_driver.sv
// -----------------------------------------------------------------------------
// tb_dac_spi_driver
//
// Two drivers run side by side: unit 0 with SCLK_DIV=4 and unit 1 with
// SCLK_DIV=1. A negedge monitor captures dac_din on each rising dac_sclk while
// CS is low. It also counts CS-low cycles and done pulses. Expected frames and
// timing come from the frame format and the cycle formulas.
// -----------------------------------------------------------------------------
module tb_dac_spi_driver;

  localparam logic [3:0] CTRL = 4'b0111;
  localparam int DIV0 = 4;
  localparam int DIV1 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_s [2];
  logic [7:0] data_s  [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       cs_n_s  [2];
  logic       sclk_s  [2];
  logic       din_s   [2];

  logic        mon_clr;
  logic [15:0] cap       [2];
  int          nbits     [2];
  int          cs_low    [2];
  int          done_cnt  [2];
  logic        sclk_prev [2];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dac_spi_driver #(.SCLK_DIV(DIV0), .CTRL_BITS(CTRL)) u_div4 (
    .clk(clk), .rst_n(rst_n), .data_in(data_s[0]), .start(start_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .dac_cs_n(cs_n_s[0]),
    .dac_sclk(sclk_s[0]), .dac_din(din_s[0])
  );

  dac_spi_driver #(.SCLK_DIV(DIV1), .CTRL_BITS(CTRL)) u_div1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_s[1]), .start(start_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .dac_cs_n(cs_n_s[1]),
    .dac_sclk(sclk_s[1]), .dac_din(din_s[1])
  );

  // Monitor: this is what the DAC would see on its pins.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      sclk_prev[k] <= sclk_s[k];
      if (mon_clr) begin
        cap[k]      <= '0;
        nbits[k]    <= 0;
        cs_low[k]   <= 0;
        done_cnt[k] <= 0;
      end else begin
        if (cs_n_s[k] === 1'b0) cs_low[k] <= cs_low[k] + 1;
        if (cs_n_s[k] === 1'b0 && sclk_s[k] === 1'b1 && sclk_prev[k] === 1'b0) begin
          cap[k]   <= {cap[k][14:0], din_s[k]};
          nbits[k] <= nbits[k] + 1;
        end
        if (done_s[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
      end
    end
  end

  function automatic int div_of(input int u);
    return (u == 0) ? DIV0 : DIV1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame on unit u. mid_change flips data_in during the frame, and
  // mid_start pulses start 20 cycles in. Neither may affect the frame.
  task automatic run_frame(input int u, input logic [7:0] d, input bit mid_change, input bit mid_start);
    int          div       = div_of(u);
    int          lat       = 1 + 33 * div;
    logic [15:0] exp_frame = {CTRL, d, 4'b0000};
    int          n;
    @(posedge clk); #1;
    data_s[u]  = d;
    start_s[u] = 1'b1;
    mon_clr    = 1'b1;
    @(posedge clk); #1;
    start_s[u] = 1'b0;
    mon_clr    = 1'b0;
    n = 1;
    check("cs_low_after_start", 32'(cs_n_s[u]), 0);
    check("busy_after_start",   32'(busy_s[u]), 1);
    check("msb_after_start",    32'(din_s[u]),  32'(exp_frame[15]));
    check("sclk_low_at_start",  32'(sclk_s[u]), 0);
    while (done_s[u] !== 1'b1 && n < lat + 20) begin
      @(posedge clk); #1;
      n++;
      if (mid_change && n == 3) data_s[u] = ~d;
      start_s[u] = (mid_start && n == 20) ? 1'b1 : 1'b0;
    end
    start_s[u] = 1'b0;
    check("done_latency",  32'(n), 32'(lat));
    check("busy_at_done",  32'(busy_s[u]), 0);
    check("cs_high_at_done", 32'(cs_n_s[u]), 1);
    @(negedge clk); #1;
    check("frame_bits",  32'(cap[u]), 32'(exp_frame));
    check("rise_count",  32'(nbits[u]), 16);
    check("cs_low_time", 32'(cs_low[u]), 32'(32 * div));
    check("done_pulses", 32'(done_cnt[u]), 1);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done_s[u]), 0);
    check("idle_after_done", 32'(busy_s[u]), 0);
    $display("frame unit=%0d data=%02h sent=%04h latency=%0d", u, d, cap[u], n);
  endtask

  initial begin
    int          n;
    int          gap;
    logic [7:0]  d;
    logic [15:0] exp_frame;

    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0;
      data_s[k]  = 8'h00;
    end
    mon_clr = 1'b1;

    // Outputs while reset is held.
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_cs_n", 32'(cs_n_s[k]), 1);
      check("rst_sclk", 32'(sclk_s[k]), 0);
      check("rst_din",  32'(din_s[k]),  0);
      check("rst_busy", 32'(busy_s[k]), 0);
      check("rst_done", 32'(done_s[k]), 0);
    end
    $display("reset held: outputs checked on both units");
    rst_n = 1'b1;

    // Directed frames.
    run_frame(0, 8'h80, 1'b0, 1'b0);
    run_frame(0, 8'hFF, 1'b1, 1'b0);
    run_frame(1, 8'hA5, 1'b0, 1'b0);
    run_frame(0, 8'h3C, 1'b0, 1'b1);

    // start held high: frames back to back.
    d         = 8'($urandom);
    exp_frame = {CTRL, d, 4'b0000};
    @(posedge clk); #1;
    data_s[0]  = d;
    start_s[0] = 1'b1;
    mon_clr    = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    n = 0;
    while (cs_n_s[0] !== 1'b1 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    gap = 0;
    while (cs_n_s[0] === 1'b1 && gap < 50) begin
      @(posedge clk); #1; gap++;
    end
    check("b2b_cs_gap", 32'(gap), 32'(DIV0 + 1));
    check("b2b_done_first", 32'(done_cnt[0]), 1);
    start_s[0] = 1'b0;
    n = 0;
    while (done_s[0] !== 1'b1 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk); #1;
    check("b2b_done_second", 32'(done_cnt[0]), 2);
    check("b2b_frame", 32'(cap[0]), 32'(exp_frame));
    $display("back-to-back: data=%02h gap=%0d dones=%0d", d, gap, done_cnt[0]);

    // Reset 60 cycles into a frame.
    @(posedge clk); #1;
    data_s[0]  = 8'($urandom);
    start_s[0] = 1'b1;
    mon_clr    = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    mon_clr    = 1'b0;
    repeat (59) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", 32'(cs_n_s[0]), 1);
    check("abort_sclk", 32'(sclk_s[0]), 0);
    check("abort_busy", 32'(busy_s[0]), 0);
    check("abort_din",  32'(din_s[0]),  0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt[0]), 0);
    $display("mid-frame reset: cs_n=%0b busy=%0b dones=%0d", cs_n_s[0], busy_s[0], done_cnt[0]);
    run_frame(0, 8'($urandom), 1'b0, 1'b0);

    // Randomised frames on both units.
    for (int i = 0; i < 8; i++) begin
      run_frame(int'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
